// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract unit: SEGMENT bits of the carry chain resolve per stage,
// unresolved operand slices ride alongside the partial sum; valid/ready on both ports.
module pipelined_add_sub #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SEGMENT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned STAGES = WIDTH / SEGMENT;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  if (WIDTH < 2 || (WIDTH % SEGMENT) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of SEGMENT");
  end

  // Stage k input view: index 0 is the prepared operand beat, k>0 is register k-1.
  logic             st_vld [STAGES];
  logic [WIDTH-1:0] st_acc [STAGES];
  logic [WIDTH-1:0] st_bp  [STAGES];
  logic             st_cy  [STAGES];
  logic             st_sat [STAGES];

  logic             adv;
  logic             c0;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  always_comb begin
    c0 = 1'b0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_ADC:  c0 = cin;
      OP_SUB:  c0 = 1'b1;
      OP_SBB:  c0 = ~cin;
      default: c0 = 1'b0;
    endcase
  end

  assign adv       = !(out_valid_q && !out_ready);
  assign in_ready  = adv;

  assign st_vld[0] = in_valid;
  assign st_acc[0] = a;
  assign st_bp[0]  = op[1] ? ~b : b;
  assign st_cy[0]  = c0;
  assign st_sat[0] = sat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEGMENT:0] seg_sum;
    logic [WIDTH-1:0] acc_next;

    // acc holds resolved sum bits below slice k and untouched operand A above it.
    always_comb begin
      seg_sum  = {1'b0, SEGMENT'(st_acc[k] >> (k * SEGMENT))}
               + {1'b0, SEGMENT'(st_bp[k] >> (k * SEGMENT))}
               + {{SEGMENT{1'b0}}, st_cy[k]};
      acc_next = st_acc[k];
      acc_next[k*SEGMENT +: SEGMENT] = seg_sum[SEGMENT-1:0];
    end

    if (k < STAGES - 1) begin : g_reg
      logic             vld_q, vld_d;
      logic             cy_q, cy_d;
      logic             sat_q, sat_d;
      logic [WIDTH-1:0] acc_q, acc_d;
      logic [WIDTH-1:0] bp_q, bp_d;

      always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        sat_d = sat_q;
        acc_d = acc_q;
        bp_d  = bp_q;
        if (adv) begin
          vld_d = st_vld[k];
          cy_d  = seg_sum[SEGMENT];
          sat_d = st_sat[k];
          acc_d = acc_next;
          bp_d  = st_bp[k];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          sat_q <= 1'b0;
          acc_q <= '0;
          bp_q  <= '0;
        end else begin
          vld_q <= vld_d;
          cy_q  <= cy_d;
          sat_q <= sat_d;
          acc_q <= acc_d;
          bp_q  <= bp_d;
        end
      end

      assign st_vld[k+1] = vld_q;
      assign st_cy[k+1]  = cy_q;
      assign st_sat[k+1] = sat_q;
      assign st_acc[k+1] = acc_q;
      assign st_bp[k+1]  = bp_q;
    end else begin : g_out
      logic             a_msb;
      logic             bp_msb;
      logic             ovf;
      logic [WIDTH-1:0] fin;

      // Top slice is still raw operand A here, so its MSB is a[MSB].
      always_comb begin
        a_msb  = st_acc[k][WIDTH-1];
        bp_msb = st_bp[k][WIDTH-1];
        ovf    = (a_msb == bp_msb) && (acc_next[WIDTH-1] != a_msb);
        fin    = acc_next;
        if (st_sat[k] && ovf) begin
          fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        if (adv) begin
          out_valid_d = st_vld[k];
          if (st_vld[k]) begin
            result_d   = fin;
            carry_d    = seg_sum[SEGMENT];
            overflow_d = ovf;
            zero_d     = (fin == '0);
            negative_d = fin[WIDTH-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          carry_q     <= 1'b0;
          overflow_q  <= 1'b0;
          zero_q      <= 1'b0;
          negative_q  <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
          result_q    <= result_d;
          carry_q     <= carry_d;
          overflow_q  <= overflow_d;
          zero_q      <= zero_d;
          negative_q  <= negative_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed corner vectors plus randomized
// streams with stalls/bubbles checked against an arithmetic reference model.
module tb_pipelined_add_sub;

  typedef longint unsigned u64_t;
  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  op;
    logic        sat;
    logic [15:0] r;
    logic [3:0]  f;
  } dvec_t;

  localparam int MAIN_LAT = 4;

  int n_vec = 0;
  int n_err = 0;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, cin, sat, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [1:0]  op;
  logic        carry, overflow, zero, negative;

  logic        w8_in_valid, w8_in_ready, w8_cin, w8_sat, w8_out_valid, w8_out_ready;
  logic [7:0]  w8_a, w8_b, w8_result;
  logic [1:0]  w8_op;
  logic        w8_carry, w8_overflow, w8_zero, w8_negative;

  logic        w32_in_valid, w32_in_ready, w32_cin, w32_sat, w32_out_valid, w32_out_ready;
  logic [31:0] w32_a, w32_b, w32_result;
  logic [1:0]  w32_op;
  logic        w32_carry, w32_overflow, w32_zero, w32_negative;

  dvec_t dtab [13];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .SEGMENT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  pipelined_add_sub #(.WIDTH(8), .SEGMENT(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .a(w8_a), .b(w8_b), .cin(w8_cin), .op(w8_op), .sat(w8_sat),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .result(w8_result),
    .carry(w8_carry), .overflow(w8_overflow), .zero(w8_zero), .negative(w8_negative)
  );

  pipelined_add_sub #(.WIDTH(32), .SEGMENT(8)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
    .a(w32_a), .b(w32_b), .cin(w32_cin), .op(w32_op), .sat(w32_sat),
    .out_valid(w32_out_valid), .out_ready(w32_out_ready), .result(w32_result),
    .carry(w32_carry), .overflow(w32_overflow), .zero(w32_zero), .negative(w32_negative)
  );

  // Reference: true integer arithmetic, then wrap / clamp to w bits.
  function automatic exp_t ref_calc(input int w, input u64_t ua, input u64_t ub,
                                    input bit icin, input bit [1:0] iop, input bit isat);
    exp_t   e;
    u64_t   m;
    u64_t   half;
    u64_t   ur;
    longint sa, sb, sr, ext;
    m    = u64_t'(1) << w;
    half = m >> 1;
    ext  = (iop == 2'b01 || iop == 2'b11) ? longint'(icin) : 0;
    sa   = (ua >= half) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - longint'(m) : longint'(ub);
    if (iop == 2'b00 || iop == 2'b01) begin
      ur  = ua + ub + u64_t'(ext);
      e.c = (ur >= m);
      sr  = sa + sb + ext;
    end else begin
      e.c = (ua >= ub + u64_t'(ext));
      ur  = ua + 2 * m - ub - u64_t'(ext);
      sr  = sa - sb - ext;
    end
    ur  = ur % m;
    e.v = (sr > longint'(half) - 1) || (sr < -longint'(half));
    if (isat && e.v) ur = (sr > 0) ? half - 1 : half;
    e.res = 32'(ur);
    e.z   = (ur == 0);
    e.n   = (ur >= half);
    return e;
  endfunction

  task automatic send_one(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic [1:0] iop, input logic isat, output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = icin; op = iop; sat = isat;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 2'b00; sat = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || result !== 16'h0 || {carry, overflow, zero, negative} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_outputs: out_valid=%b result=%h flags=%b, want 0 0000 0000",
               out_valid, result, {carry, overflow, zero, negative});
    end
    n_vec++;
    if (w8_out_valid !== 1'b0 || w32_out_valid !== 1'b0 || w8_result !== 8'h0 || w32_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_corners: w8 valid=%b res=%h w32 valid=%b res=%h, want 0 0",
               w8_out_valid, w8_result, w32_out_valid, w32_result);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (MAIN_LAT + 3) begin
      @(negedge clk);
      seen |= out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_capture: out_valid seen=%b, want 0", seen);
    end
  endtask

  task automatic test_directed();
    int lat;
    dtab = '{
      '{"add_basic",      16'h1234, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h1235, 4'b0000},
      '{"add_seg_carry",  16'h0FFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h1000, 4'b0000},
      '{"add_wrap",       16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h0000, 4'b1010},
      '{"adc_cin",        16'h00FF, 16'h0000, 1'b1, 2'b01, 1'b0, 16'h0100, 4'b0000},
      '{"adc_nocin",      16'h0001, 16'h0001, 1'b0, 2'b01, 1'b0, 16'h0002, 4'b0000},
      '{"sub_borrow",     16'h0005, 16'h0007, 1'b0, 2'b10, 1'b0, 16'hFFFE, 4'b0001},
      '{"sub_equal",      16'h0007, 16'h0007, 1'b0, 2'b10, 1'b0, 16'h0000, 4'b1010},
      '{"sbb_cin",        16'h0010, 16'h0001, 1'b1, 2'b11, 1'b0, 16'h000E, 4'b1000},
      '{"sbb_nocin",      16'h0010, 16'h0001, 1'b0, 2'b11, 1'b0, 16'h000F, 4'b1000},
      '{"add_ovf_nosat",  16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h8000, 4'b0101},
      '{"add_ovf_sat",    16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b1, 16'h7FFF, 4'b0100},
      '{"sub_ovf_sat",    16'h8000, 16'h0001, 1'b0, 2'b10, 1'b1, 16'h8000, 4'b1101},
      '{"add_negovf_sat", 16'h8000, 16'h8000, 1'b0, 2'b00, 1'b1, 16'h8000, 4'b1101}
    };
    foreach (dtab[i]) begin
      send_one(dtab[i].a, dtab[i].b, dtab[i].cin, dtab[i].op, dtab[i].sat, lat);
      n_vec++;
      if (lat != MAIN_LAT) begin
        n_err++;
        $display("FAIL %s_latency: got %0d cycles, want %0d", dtab[i].name, lat, MAIN_LAT);
        continue;
      end
      n_vec++;
      if (result !== dtab[i].r || {carry, overflow, zero, negative} !== dtab[i].f) begin
        n_err++;
        $display("FAIL %s: result=%h cvzn=%b, want %h %b", dtab[i].name, result,
                 {carry, overflow, zero, negative}, dtab[i].r, dtab[i].f);
      end
    end
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; op = 2'b00; sat = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL inflight_reset: out_valid=%b after reset edge, want 0", out_valid);
    end
    repeat (MAIN_LAT + 4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL inflight_discard: out_valid seen=%b, want 0", seen);
    end
  endtask

  task automatic test_stream(input string name, input int n, input bit bubbles,
                             input int stall_at, input int stall_len, input bit rand_ready);
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    bit          holding = 1'b0, pending = 1'b0, seen = 1'b0;
    logic [15:0] held_res;
    logic [3:0]  held_flags;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (holding) begin
        n_vec++;
        if (out_valid !== 1'b1 || result !== held_res || {carry, overflow, zero, negative} !== held_flags) begin
          n_err++;
          $display("FAIL %s_hold: valid=%b result=%h cvzn=%b, want 1 %h %b", name, out_valid,
                   result, {carry, overflow, zero, negative}, held_res, held_flags);
        end
      end
      if (!pending) begin
        if (sent < n && (!bubbles || $urandom_range(0, 3) != 0)) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
          op = 2'($urandom); sat = 1'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
      else out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      n_vec++;
      if (out_valid && !out_ready) begin
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s_in_ready_stall: in_ready=%b, want 0", name, in_ready);
        end
        holding = 1'b1;
        held_res = result;
        held_flags = {carry, overflow, zero, negative};
      end else begin
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s_in_ready_free: in_ready=%b, want 1", name, in_ready);
        end
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        got++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s_extra_beat: result=%h with nothing outstanding, want no beat", name, result);
        end else begin
          e = q.pop_front();
          if (result !== e.res[15:0] || {carry, overflow, zero, negative} !== {e.c, e.v, e.z, e.n}) begin
            n_err++;
            $display("FAIL %s_beat%0d: result=%h cvzn=%b, want %h %b", name, got, result,
                     {carry, overflow, zero, negative}, e.res[15:0], {e.c, e.v, e.z, e.n});
          end
        end
      end
      pending = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back(ref_calc(16, u64_t'(a), u64_t'(b), cin, op, sat));
        sent++;
      end else if (in_valid) begin
        pending = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (got != n || sent != n || q.size() != 0) begin
      n_err++;
      $display("FAIL %s_count: sent=%0d got=%0d outstanding=%0d, want %0d %0d 0",
               name, sent, got, q.size(), n, n);
    end
    repeat (MAIN_LAT + 2) begin
      @(negedge clk);
      seen |= out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL %s_duplicate: out_valid seen=%b after drain, want 0", name, seen);
    end
  endtask

  task automatic test_corner_w8();
    int lat = -1;
    @(negedge clk);
    w8_a = 8'h7F; w8_b = 8'h01; w8_cin = 1'b0; w8_op = 2'b00; w8_sat = 1'b0;
    w8_in_valid = 1'b1; w8_out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      w8_in_valid = 1'b0;
      if (w8_out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL w8_latency: got %0d cycles, want 1", lat);
    end
    n_vec++;
    if (w8_result !== 8'h80 || {w8_carry, w8_overflow, w8_zero, w8_negative} !== 4'b0101) begin
      n_err++;
      $display("FAIL w8_add_ovf: result=%h cvzn=%b, want 80 0101", w8_result,
               {w8_carry, w8_overflow, w8_zero, w8_negative});
    end
  endtask

  task automatic test_corner_w32();
    int lat = -1;
    @(negedge clk);
    w32_a = 32'hFFFF_FFFF; w32_b = 32'h1; w32_cin = 1'b0; w32_op = 2'b00; w32_sat = 1'b0;
    w32_in_valid = 1'b1; w32_out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      w32_in_valid = 1'b0;
      if (w32_out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL w32_latency: got %0d cycles, want 4", lat);
    end
    n_vec++;
    if (w32_result !== 32'h0 || {w32_carry, w32_overflow, w32_zero, w32_negative} !== 4'b1010) begin
      n_err++;
      $display("FAIL w32_add_wrap: result=%h cvzn=%b, want 00000000 1010", w32_result,
               {w32_carry, w32_overflow, w32_zero, w32_negative});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00; sat = 1'b0; out_ready = 1'b1;
    w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_cin = 1'b0; w8_op = 2'b00; w8_sat = 1'b0;
    w8_out_ready = 1'b1;
    w32_in_valid = 1'b0; w32_a = '0; w32_b = '0; w32_cin = 1'b0; w32_op = 2'b00; w32_sat = 1'b0;
    w32_out_ready = 1'b1;

    test_reset();
    test_directed();
    test_reset_inflight();
    test_stream("back_to_back", 10, 1'b0, 6, 6, 1'b0);
    test_stream("bubbles", 200, 1'b1, 0, 0, 1'b1);
    test_corner_w8();
    test_corner_w32();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
